// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the UART boot loader and its byte receiver.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    WAIT_SYNC,
    LEN,
    DATA,
    CSUM,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_BITS,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam int unsigned LEN_BYTES = 4;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// one-cycle byte_valid or frame_err pulse after sampling the stop bit.
module uart_rx_byte
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned    CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  logic            r_rx_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_valid;
  logic            r_ferr;

  // NOTE: non-blocking assignments everywhere here, so every flop samples the
  // pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
      r_state   <= RX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (!r_rx_sync && r_rx_prev) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_CNT) begin
            // A start bit that is high again at mid-bit was a glitch.
            r_state <= r_rx_sync ? RX_IDLE : RX_BITS;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_BITS: begin
          if (r_cnt == FULL_CNT) begin
            r_cnt   <= '0;
            r_shift <= {r_rx_sync, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_CNT) begin
            r_state <= RX_IDLE;
            r_valid <= r_rx_sync;
            r_ferr  <= ~r_rx_sync;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = r_valid;
  assign byte_data  = r_shift;
  assign frame_err  = r_ferr;

endmodule

// File: rtl/boot_loader.sv
// UART image loader: sync/length/payload/checksum frame into RAM, core held in
// reset until the checksum matches. BOOT_LOADER_RELOAD_EN allows reload from DONE.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MEM_SIZE     = 'h2024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wd,
  output logic        core_rst_n,
  output logic        busy,
  output logic        err
);

  logic        w_byte_valid;
  logic [7:0]  w_byte_data;
  logic        w_frame_err;
  logic [31:0] w_len_next;

  state_t      r_state;
  logic [31:0] r_len;
  logic [31:0] r_idx;
  logic [7:0]  r_sum;
  logic [1:0]  r_len_cnt;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [7:0]  r_mem_wd;
  logic        r_core_rst_n;
  logic        r_busy;
  logic        r_err;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (uart_rx),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  // Length arrives little-endian, so each new byte shifts in from the top.
  assign w_len_next = {w_byte_data, r_len[31:8]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= WAIT_SYNC;
      r_len        <= '0;
      r_idx        <= '0;
      r_sum        <= '0;
      r_len_cnt    <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wd     <= '0;
      r_core_rst_n <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      if (w_frame_err && r_state != DONE) begin
        r_err   <= 1'b1;
        r_state <= WAIT_SYNC;
        r_busy  <= 1'b0;
      end else if (w_byte_valid) begin
        case (r_state)
          WAIT_SYNC: begin
            if (w_byte_data == SYNC_BYTE) begin
              r_err     <= 1'b0;
              r_len     <= '0;
              r_idx     <= '0;
              r_sum     <= '0;
              r_len_cnt <= '0;
              r_state   <= LEN;
              r_busy    <= 1'b1;
            end
          end
          LEN: begin
            r_len     <= w_len_next;
            r_len_cnt <= r_len_cnt + 2'd1;
            if (r_len_cnt == 2'(LEN_BYTES - 1)) begin
              if (w_len_next > MEM_SIZE) begin
                r_err   <= 1'b1;
                r_state <= WAIT_SYNC;
                r_busy  <= 1'b0;
              end else if (w_len_next == 32'd0) begin
                r_state <= CSUM;
              end else begin
                r_state <= DATA;
              end
            end
          end
          DATA: begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_idx;
            r_mem_wd   <= w_byte_data;
            r_sum      <= r_sum + w_byte_data;
            r_idx      <= r_idx + 32'd1;
            if (r_idx == r_len - 32'd1) r_state <= CSUM;
          end
          CSUM: begin
            r_busy <= 1'b0;
            if (w_byte_data == r_sum) begin
              r_state      <= DONE;
              r_core_rst_n <= 1'b1;
            end else begin
              r_err   <= 1'b1;
              r_state <= WAIT_SYNC;
            end
          end
          DONE: begin
`ifdef BOOT_LOADER_RELOAD_EN
            if (w_byte_data == SYNC_BYTE) begin
              r_core_rst_n <= 1'b0;
              r_err        <= 1'b0;
              r_len        <= '0;
              r_idx        <= '0;
              r_sum        <= '0;
              r_len_cnt    <= '0;
              r_state      <= LEN;
              r_busy       <= 1'b1;
            end
`else
            r_state <= DONE;
`endif
          end
          default: r_state <= WAIT_SYNC;
        endcase
      end
    end
  end

  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wd     = r_mem_wd;
  assign core_rst_n = r_core_rst_n;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: doc/boot_loader.md
# boot_loader

UART program loader sitting upstream of the core/RAM pair: it receives a framed binary image over a serial line, writes it byte-by-byte into RAM starting at address 0, and holds the core in reset until the image checksum verifies. It replaces direct testbench preloading of RAM on hardware and drives the RAM write port and the core's reset.

## Interface
- CLKS_PER_BIT, default 868: clk cycles per UART bit (100 MHz / 115200); minimum 4.
- MEM_SIZE, default 'h2024: RAM size in bytes; images longer than this are rejected.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- uart_rx  in  1  asynchronous serial input, 8N1, LSB first, idle high.
- mem_we  out  1  one-cycle RAM byte write strobe.
- mem_addr  out  32  RAM byte address for the write.
- mem_wd  out  8  RAM write data.
- core_rst_n  out  1  core reset, active-low; 0 while loading.
- busy  out  1  frame in progress (state other than WAIT_SYNC/DONE).
- err  out  1  sticky error flag.

## Operation
- Frame: sync byte 0xA5, 4-byte little-endian length N, N payload bytes, 1 checksum byte = sum of payload mod 256.
- Byte receiver: 2-flop synchronizer on uart_rx; falling edge in idle starts a bit; start bit resampled at CLKS_PER_BIT/2 (must be 0, else treated as glitch and ignored); data bits sampled every CLKS_PER_BIT thereafter; stop bit must be 1.
- Stop bit 0 = framing error: byte dropped, err set, FSM to WAIT_SYNC.
- FSM states: WAIT_SYNC, LEN, DATA, CSUM, DONE.
- WAIT_SYNC: non-0xA5 bytes discarded; 0xA5 clears err, clears length/addr/sum, -> LEN.
- LEN: collect 4 bytes. After the 4th: N > MEM_SIZE -> err=1, WAIT_SYNC; N == 0 -> CSUM; else -> DATA.
- DATA: each byte writes mem_addr = running index (0..N-1), adds to 8-bit sum (wraps); after byte N-1 -> CSUM.
- CSUM: byte == sum -> DONE, core_rst_n=1; mismatch -> err=1, WAIT_SYNC, core_rst_n stays 0.
- DONE: core running; uart bytes ignored (see Configuration).
- Reset values: mem_we 0, mem_addr 0, mem_wd 0, core_rst_n 0, busy 0, err 0, state WAIT_SYNC, receiver idle.
- rst_n low mid-frame aborts the load; no partial-frame state survives; RAM contents already written are not cleared.

## Timing
- Byte valid internally on the clk edge sampling mid stop bit.
- mem_we pulses exactly one cycle, the cycle after byte valid, with mem_addr/mem_wd stable that cycle.
- core_rst_n rises the cycle after the matching checksum byte is valid; never glitches.
- err and state updates take effect the cycle after the triggering byte valid.
- Minimum back-to-back byte spacing 10*CLKS_PER_BIT cycles; no bytes lost at full line rate.

## Configuration
- BOOT_LOADER_RELOAD_EN defined: in DONE, a received 0xA5 drops core_rst_n to 0 the next cycle and enters LEN for a new image.
- Undefined: DONE is terminal until rst_n; all uart bytes ignored in DONE.

## Structure
- Package boot_loader_pkg: state enum (WAIT_SYNC, LEN, DATA, CSUM, DONE), SYNC_BYTE = 8'hA5, LEN_BYTES = 4.
- Sub-module uart_rx_byte (clk, rst_n, rx, byte_valid, byte_data, frame_err), parameterised by CLKS_PER_BIT.

## Test plan
- CLKS_PER_BIT=4; send A5 04 00 00 00 93 00 10 00 A3 -> writes 0x93,0x00,0x10,0x00 to addr 0..3, core_rst_n 0->1 after A3, err 0.
- Same frame with checksum A4 -> four writes occur, err=1, core_rst_n stays 0, busy 0.
- Send A5 25 20 00 00 -> err=1 after 4th length byte, no mem_we, state WAIT_SYNC.
- Send A5 00 00 00 00 00 -> no writes, core_rst_n rises.
- Stop bit forced 0 on 2nd payload byte -> err=1, no write for that byte, later A5 clears err.
- rst_n low for 1 cycle after 2 payload bytes -> core_rst_n 0, err 0, new full frame loads correctly; with BOOT_LOADER_RELOAD_EN, A5 in DONE drops core_rst_n next cycle.
